// File: rtl/reg_enc_pkg.sv
// Shared constants and types for the register write encoder.
package reg_enc_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  // First round-robin search after reset starts at register 0.
  localparam logic [ADDR_W-1:0] LastGrantRst = 5'd31;

endpackage

// File: rtl/find_first_set_32.sv
// Combinational 32-to-5 priority encoder: lowest set bit wins.
module find_first_set_32
  import reg_enc_pkg::*;
(
  input  logic [NUM_REGS-1:0] vec_i,
  output logic [ADDR_W-1:0]   idx_o,
  output logic                found_o
);

  always_comb begin
    idx_o = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = ADDR_W'(i);
      end
    end
    found_o = |vec_i;
  end

endmodule

// File: rtl/reg_write_encoder.sv
// Serializes a multi-hot write mask into single RegWrite/WriteRegister strobes.
// Define REG_ENC_ROUND_ROBIN_EN for round-robin selection instead of fixed priority.
module reg_write_encoder
  import reg_enc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [NUM_REGS-1:0] req_mask,
  output logic                req_ready,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   WriteRegister,
  input  logic                wr_ready,
  output logic                done
);

  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   ffs_idx;
  logic                ffs_found;
  logic [ADDR_W-1:0]   sel;
  logic                grant;

`ifdef REG_ENC_ROUND_ROBIN_EN
  logic [ADDR_W-1:0]     last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]     offset;
  logic [2*NUM_REGS-1:0] doubled;
  logic [NUM_REGS-1:0]   rotated;

  // Rotate so the search origin lands at bit 0, then map the hit back.
  assign offset  = last_grant_q + ADDR_W'(1);
  assign doubled = {pending_q, pending_q} >> offset;
  assign rotated = doubled[NUM_REGS-1:0];

  find_first_set_32 u_ffs (
    .vec_i   (rotated),
    .idx_o   (ffs_idx),
    .found_o (ffs_found)
  );

  assign sel = ffs_idx + offset;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant) begin
      last_grant_d = sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= LastGrantRst;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  find_first_set_32 u_ffs (
    .vec_i   (pending_q),
    .idx_o   (ffs_idx),
    .found_o (ffs_found)
  );

  assign sel = ffs_idx;
`endif

  assign grant = (state_q == ISSUE) && wr_ready && ffs_found;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          pending_d = req_mask;
          if (req_mask == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (grant) begin
          pending_d = pending_q & ~(NUM_REGS'(1) << sel);
          if (pending_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only
  always_comb begin
    req_ready     = (state_q == IDLE);
    RegWrite      = (state_q == ISSUE);
    WriteRegister = (state_q == ISSUE) ? sel : '0;
    done          = done_q;
  end

endmodule

// File: tb/tb_reg_write_encoder.sv
// Self-checking bench: directed scenarios plus random traffic against a mask-level model.
module tb_reg_write_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_mask;
  logic        req_ready;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic        wr_ready;
  logic        done;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding mask, busy flag, last granted register.
  bit          m_busy;
  bit [31:0]   m_pend;
  int          m_last;
  bit          m_done;

  always #5 clk = ~clk;

  reg_write_encoder dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_mask      (req_mask),
    .req_ready     (req_ready),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .wr_ready      (wr_ready),
    .done          (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input bit [31:0] pend, input int last);
    int start;
`ifdef REG_ENC_ROUND_ROBIN_EN
    start = (last + 1) % 32;
`else
    start = 0;
`endif
    for (int k = 0; k < 32; k++) begin
      if (pend[(start + k) % 32]) return (start + k) % 32;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_pend = '0;
    m_last = 31;
    m_done = 0;
  endtask

  task automatic check_outputs(input string ctx);
    check_eq({ctx, ".req_ready"}, 32'(req_ready), 32'(!m_busy));
    check_eq({ctx, ".RegWrite"}, 32'(RegWrite), 32'(m_busy));
    check_eq({ctx, ".WriteRegister"}, 32'(WriteRegister),
             m_busy ? 32'(pick(m_pend, m_last)) : 32'd0);
    check_eq({ctx, ".done"}, 32'(done), 32'(m_done));
  endtask

  // Apply inputs for one cycle, advance the model at the edge, then check.
  task automatic step(input bit rv, input bit [31:0] rm, input bit wr, input string ctx);
    int g;
    req_valid = rv;
    req_mask  = rm;
    wr_ready  = wr;
    @(posedge clk);
    m_done = 0;
    if (!m_busy) begin
      if (rv) begin
        m_pend = rm;
        if (rm == 0) m_done = 1;
        else m_busy = 1;
      end
    end else if (wr) begin
      g = pick(m_pend, m_last);
      m_pend[g] = 1'b0;
      m_last = g;
      if (m_pend == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end
    #1;
    check_outputs(ctx);
  endtask

  initial begin
    bit [31:0] rm;
    int        kind;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_mask  = '0;
    wr_ready  = 1'b0;
    model_reset();
    #12;
    check_outputs("rst");
    reset = 1'b0;

    // Single bit
    step(1, 32'h0000_0001, 1, "single_acc");
    check_eq("single_wr0", 32'(WriteRegister), 32'd0);
    step(0, 0, 1, "single_done");
    check_eq("single_done_pulse", 32'(done), 32'd1);
    step(0, 0, 1, "single_after");

    // Multi-bit, three consecutive writes then done
    step(1, 32'h8000_0011, 1, "multi_acc");
    check_eq("multi_first", 32'(WriteRegister), 32'd0);
    step(0, 0, 1, "multi_g0");
    check_eq("multi_second", 32'(WriteRegister), 32'd4);
    step(0, 0, 1, "multi_g4");
    check_eq("multi_third", 32'(WriteRegister), 32'd31);
    step(0, 0, 1, "multi_g31");
    check_eq("multi_done", 32'(done), 32'd1);
    step(0, 0, 1, "multi_after");

    // Backpressure after first grant
    step(1, 32'h0000_0030, 1, "bp_acc");
    step(0, 0, 1, "bp_g4");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, "bp_stall");
      check_eq("bp_hold_idx", 32'(WriteRegister), 32'd5);
      check_eq("bp_hold_wr", 32'(RegWrite), 32'd1);
    end
    step(0, 0, 1, "bp_g5");
    check_eq("bp_done", 32'(done), 32'd1);

    // Zero mask, then accept a new mask in the done cycle
    step(1, 32'h0000_0000, 1, "zero_acc");
    check_eq("zero_done", 32'(done), 32'd1);
    check_eq("zero_nowrite", 32'(RegWrite), 32'd0);
    step(1, 32'h0000_0004, 1, "zero_next_acc");
    check_eq("zero_next_idx", 32'(WriteRegister), 32'd2);
    step(0, 0, 1, "zero_next_g2");
    step(0, 0, 1, "zero_next_idle");

    // Reset mid-batch after register 4 is granted
    step(1, 32'h0000_00F0, 1, "rst_acc");
    step(0, 0, 1, "rst_g4");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_mid");
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, "rst_quiet");
    end

    // Round-robin behaviour across batches (fresh reset)
    step(1, 32'h0000_0001, 1, "rr_b1");
    step(0, 0, 1, "rr_b1_g0");
    step(1, 32'h0000_0003, 1, "rr_b2_acc");
`ifdef REG_ENC_ROUND_ROBIN_EN
    check_eq("rr_b2_first", 32'(WriteRegister), 32'd1);
    step(0, 0, 1, "rr_b2_g");
    check_eq("rr_b2_second", 32'(WriteRegister), 32'd0);
`else
    check_eq("rr_b2_first", 32'(WriteRegister), 32'd0);
    step(0, 0, 1, "rr_b2_g");
    check_eq("rr_b2_second", 32'(WriteRegister), 32'd1);
`endif
    step(0, 0, 1, "rr_b2_end");

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) rm = '0;
      else if (kind < 3) rm = 32'd1 << $urandom_range(0, 31);
      else if (kind < 6) rm = $urandom & $urandom & $urandom;
      else rm = $urandom;
      step(bit'($urandom_range(0, 1)), rm, ($urandom_range(0, 9) < 7), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_write_encoder.md
# reg_write_encoder

Serializes a 32-bit multi-hot register write-request mask into a stream of single register writes, one per accepted cycle, as a RegWrite strobe plus 5-bit WriteRegister index. It is the encoding end of the register file's write-select path: its outputs connect directly to the 5:32 write-enable decoder's RegWrite and WriteRegister inputs. Typical sources are multi-register writeback, such as load-multiple or context restore.

## Interface
- NUM_REGS, 32, register count; fixed by package, not overridable
- ADDR_W, 5, index width; equals clog2(NUM_REGS)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request mask present
- req_mask  in  32  registers to write; bit i means register i
- req_ready  out  1  block idle and able to accept a mask
- RegWrite  out  1  write strobe, valid for the current WriteRegister
- WriteRegister  out  5  register index being written
- wr_ready  in  1  register file accepts the write this cycle
- done  out  1  one-cycle pulse when a batch completes

One clock; reset is asynchronous and active-high (ports clk, reset).

## Operation
- States: IDLE and ISSUE.
- IDLE:
  - req_ready=1, RegWrite=0.
  - req_valid at a clock edge latches req_mask into the pending register.
  - If the mask is nonzero, go to ISSUE.
  - If the mask is zero, stay in IDLE and pulse done next cycle.
- ISSUE:
  - req_ready=0, RegWrite=1.
  - WriteRegister = selected set bit of pending.
  - On an edge with wr_ready=1 (a grant): clear that bit and update last_grant.
  - If pending becomes zero, return to IDLE and pulse done.
- wr_ready=0 holds WriteRegister and pending unchanged. A write is never dropped or duplicated.
- Selection is fixed-priority, lowest index first (see Configuration for round-robin).
- req_valid is ignored outside IDLE. The mask is sampled only on the accepting edge.
- Outputs are functions of registered state only; there is no combinational path from req_* or wr_ready to RegWrite or WriteRegister.
- Reset, including mid-batch, forces immediately:
  - state IDLE, pending 0, last_grant 31
  - RegWrite 0, WriteRegister 0, done 0, req_ready 1
- Pending writes are discarded on reset.

## Timing
- Accept edge N puts RegWrite high in cycle N+1.
- With wr_ready held at 1, a k-bit mask issues on k consecutive cycles.
- done is high the cycle after the final grant. The block is already in IDLE then, so a new mask may be accepted that same cycle.
- Zero mask: done is high in the cycle after acceptance, with no RegWrite.
- Each stalled cycle (wr_ready=0) adds exactly one cycle of latency.

## Configuration
- Macro: REG_ENC_ROUND_ROBIN_EN.
- Defined:
  - Search starts at (last_grant+1) mod 32 and wraps.
  - last_grant persists across batches and is reset to 31, so the first search starts at 0.
- Undefined:
  - Lowest set index always wins.
  - last_grant logic is compiled out.
- Both modes are identical for the first batch after reset.

## Structure
- Package reg_enc_pkg holds:
  - NUM_REGS=32, ADDR_W=5
  - state enum typedef {IDLE, ISSUE}
  - reset constant for last_grant (31)
- Sub-module find_first_set_32: combinational 32-to-5 priority encoder with a found flag.
- Round-robin is built by rotating pending by last_grant+1 before find_first_set_32, then adding the offset back mod 32.

## Test plan
- Reset:
  - Assert reset mid-batch (mask 0x0000_00F0, after reg 4 is granted).
  - Required: RegWrite=0, WriteRegister=0, done=0 and req_ready=1 immediately.
  - After release, no further writes occur.
- Single bit: mask 0x0000_0001 with wr_ready=1.
  - Required: one cycle RegWrite=1 with WriteRegister=0, then a done pulse.
- Multi-bit: mask 0x8000_0011 with wr_ready=1.
  - Required: WriteRegister 0, 4, 31 on three consecutive cycles.
  - done on the fourth cycle.
- Backpressure: mask 0x0000_0030 with wr_ready low for 3 cycles after the first grant.
  - Required: WriteRegister holds 5 stable with RegWrite=1 for those 3 cycles.
  - done arrives 3 cycles late.
- Zero mask: mask 0x0000_0000.
  - Required: no RegWrite; done in the cycle after acceptance.
  - A new mask is accepted in that same done cycle.
- Round-robin: batch 0x0000_0001, then batch 0x0000_0003.
  - With REG_ENC_ROUND_ROBIN_EN: second batch order is 1 then 0.
  - Without it: second batch order is 0 then 1.
